// File: rtl/writeback_regfile.sv
// Writeback result select plus RV32I integer register file: reads are combinational, a commit is visible through the array after the clock edge.
// No backpressure: a commit happens on every edge where RegWriteW is set, and a same-cycle bypass (BYPASS=1) hides that edge from decode.
module writeback_regfile #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWriteW,
   input  logic [ADDR_W-1:0] RdW,
   input  logic [1:0]        ResultSrcW,
   input  logic [XLEN-1:0]   ALUResultW,
   input  logic [XLEN-1:0]   ReadDataW,
   input  logic [XLEN-1:0]   PCPlus4W,
   input  logic [ADDR_W-1:0] Rs1D,
   input  logic [ADDR_W-1:0] Rs2D,
   output logic [XLEN-1:0]   RD1D,
   output logic [XLEN-1:0]   RD2D,
   output logic [XLEN-1:0]   ResultW
);

   localparam logic [1:0]      SRC_ALU  = 2'b00;
   localparam logic [1:0]      SRC_LOAD = 2'b01;
   localparam logic [1:0]      SRC_PC4  = 2'b10;
   localparam logic [ADDR_W:0] NREG_IDX = (ADDR_W + 1)'(NREG);

   logic [XLEN-1:0] regArray [NREG];
   logic            writeEn;
   logic            rs1Valid;
   logic            rs2Valid;
   logic            bypass1;
   logic            bypass2;

   always_comb begin
      case (ResultSrcW)
         SRC_ALU:  ResultW = ALUResultW;
         SRC_LOAD: ResultW = ReadDataW;
         SRC_PC4:  ResultW = PCPlus4W;
         default:  ResultW = ALUResultW;
      endcase
   end

   // x0 and indices beyond NREG never commit, so they can never be bypassed either.
   assign writeEn  = RegWriteW && (RdW != '0) && ({1'b0, RdW} < NREG_IDX);
   assign rs1Valid = (Rs1D != '0) && ({1'b0, Rs1D} < NREG_IDX);
   assign rs2Valid = (Rs2D != '0) && ({1'b0, Rs2D} < NREG_IDX);
   assign bypass1  = (BYPASS != 0) && !reset && writeEn && (Rs1D == RdW);
   assign bypass2  = (BYPASS != 0) && !reset && writeEn && (Rs2D == RdW);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regArray[i] <= '0;
         end
      end else if (writeEn) begin
         regArray[RdW] <= ResultW;
      end
   end

   always_comb begin
      RD1D = '0;
      if (bypass1) begin
         RD1D = ResultW;
      end else if (rs1Valid) begin
         RD1D = regArray[Rs1D];
      end
   end

   always_comb begin
      RD2D = '0;
      if (bypass2) begin
         RD2D = ResultW;
      end else if (rs2Valid) begin
         RD2D = regArray[Rs2D];
      end
   end

   x0Rd1Zero: assert property (@(posedge clk) disable iff (reset) (Rs1D == '0) |-> (RD1D == '0));
   x0Rd2Zero: assert property (@(posedge clk) disable iff (reset) (Rs2D == '0) |-> (RD2D == '0));

endmodule
